// File: rtl/spi_frame_pkg.sv
// Shared definitions for spi_frame_tx_ctrl: FSM state encoding, byte-count
// and checksum helpers.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int MAX_DATA_W = 32;

  function automatic int num_bytes(input int w);
    return (w + 7) / 8;
  endfunction

  // XOR of the n least-significant bytes of word.
  function automatic logic [7:0] xor_bytes(input logic [MAX_DATA_W-1:0] word, input int n);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (i < n) begin
        acc = acc ^ word[i*8 +: 8];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/spi_frame_tx_ctrl.sv
// SPI frame sequencer: snapshots a word on trigger and sends it MSB byte first
// under one SS window, collecting MISO bytes. Define CHECKSUM_EN to append an XOR byte.
module spi_frame_tx_ctrl
  import spi_frame_pkg::*;
#(
  parameter int DATA_W       = 14,
  parameter int SS_SETUP_CYC = 1,
  parameter int SS_HOLD_CYC  = 1,
  parameter int DROP_CNT_W   = 8,
  localparam int NUM_BYTES   = num_bytes(DATA_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_trigger,
  input  logic [DATA_W-1:0]      i_data,
  output logic                   spi_start,
  output logic [7:0]             spi_tx_data,
  input  logic [7:0]             spi_rx_data,
  input  logic                   spi_done,
  output logic                   ss,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [NUM_BYTES*8-1:0] o_rx_data,
  output logic                   o_rx_valid,
  output logic [DROP_CNT_W-1:0]  o_drop_cnt
);

  localparam int RX_W = NUM_BYTES * 8;
`ifdef CHECKSUM_EN
  localparam int TOT_BYTES = NUM_BYTES + 1;
`else
  localparam int TOT_BYTES = NUM_BYTES;
`endif
  localparam int TOT_W   = TOT_BYTES * 8;
  localparam int IDX_W   = 3;
  localparam int CNT_MAX = (SS_SETUP_CYC > SS_HOLD_CYC) ? SS_SETUP_CYC : SS_HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TOT_BYTES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD_CYC - 1);

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [TOT_W-1:0]        tx_sh_r;
  logic [RX_W-1:0]         rx_sh_r;
  logic [RX_W-1:0]         rx_data_r;
  logic [7:0]              tx_byte_r;
  logic                    ss_r;
  logic                    busy_r;
  logic                    start_r;
  logic                    frame_done_r;
  logic                    rx_valid_r;
  logic [DROP_CNT_W-1:0]   drop_r;
  logic [RX_W-1:0]         payload_s;
  logic [TOT_W-1:0]        frame_s;
  logic [RX_W-1:0]         rx_next_s;

  // Frame image loaded on an accepted trigger, and the rx shift-in value.
  always_comb begin
    payload_s = RX_W'(i_data);
`ifdef CHECKSUM_EN
    frame_s   = {payload_s, xor_bytes(MAX_DATA_W'(payload_s), NUM_BYTES)};
`else
    frame_s   = payload_s;
`endif
    rx_next_s = (rx_sh_r << 4'd8) | RX_W'(spi_rx_data);
  end

  // Frame sequencer: SS timing, byte issue, MISO collection and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      tx_sh_r      <= '0;
      rx_sh_r      <= '0;
      rx_data_r    <= '0;
      tx_byte_r    <= 8'h00;
      ss_r         <= 1'b1;
      busy_r       <= 1'b0;
      start_r      <= 1'b0;
      frame_done_r <= 1'b0;
      rx_valid_r   <= 1'b0;
    end else begin
      start_r      <= 1'b0;
      frame_done_r <= 1'b0;
      rx_valid_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_trigger) begin
            tx_sh_r <= frame_s;
            rx_sh_r <= '0;
            idx_r   <= '0;
            cnt_r   <= '0;
            ss_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          // start is raised on entry to SEND so SS leads it by exactly SS_SETUP_CYC
          if (cnt_r == SETUP_LAST) begin
            start_r   <= 1'b1;
            tx_byte_r <= tx_sh_r[TOT_W-1 -: 8];
            tx_sh_r   <= tx_sh_r << 4'd8;
            state_r   <= ST_SEND;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_SEND: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done) begin
`ifdef CHECKSUM_EN
            if (idx_r != LAST_IDX) begin
              rx_sh_r <= rx_next_s;
            end else begin
              rx_sh_r <= rx_sh_r;
            end
`else
            rx_sh_r <= rx_next_s;
`endif
            if (idx_r == LAST_IDX) begin
              cnt_r   <= '0;
              state_r <= ST_HOLD;
            end else begin
              idx_r     <= idx_r + IDX_W'(1);
              start_r   <= 1'b1;
              tx_byte_r <= tx_sh_r[TOT_W-1 -: 8];
              tx_sh_r   <= tx_sh_r << 4'd8;
              state_r   <= ST_SEND;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            ss_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
            rx_valid_r   <= 1'b1;
            rx_data_r    <= rx_sh_r;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          ss_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of triggers that arrive while a frame is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_r <= '0;
    end else if (i_trigger && busy_r && (drop_r != {DROP_CNT_W{1'b1}})) begin
      drop_r <= drop_r + DROP_CNT_W'(1);
    end else begin
      drop_r <= drop_r;
    end
  end

  assign spi_start    = start_r;
  assign spi_tx_data  = tx_byte_r;
  assign ss           = ss_r;
  assign o_busy       = busy_r;
  assign o_frame_done = frame_done_r;
  assign o_rx_data    = rx_data_r;
  assign o_rx_valid   = rx_valid_r;
  assign o_drop_cnt   = drop_r;

endmodule

// File: tb/tb_spi_frame_tx_ctrl.sv
// Directed bench for spi_frame_tx_ctrl: two configurations, each with a
// behavioural spi_master responder that logs MOSI bytes and frame timing.
module tb_spi_frame_tx_ctrl;

  localparam int LAT = 9;
`ifdef CHECKSUM_EN
  localparam int NBT_A = 3;
`else
  localparam int NBT_A = 2;
`endif
  localparam int BUSY_A = 1 + NBT_A * (LAT + 1) + 1;

  logic        clk, reset;
  logic        a_trig, a_start, a_done, a_ss, a_busy, a_fd, a_rxv;
  logic [13:0] a_data;
  logic [7:0]  a_tx, a_rx, a_drop;
  logic [15:0] a_rxd;
  logic        b_trig, b_start, b_done, b_ss, b_busy, b_fd, b_rxv;
  logic [31:0] b_data, b_rxd;
  logic [7:0]  b_tx, b_rx;
  logic [3:0]  b_drop;

  int checks, errors;

  int a_cyc, a_ss_falls, a_ss_fall_cyc, a_ss_rise_cyc, a_first_start, a_last_done;
  int a_fd_cnt, a_fd_cyc, a_stray, a_tx_bad;
  logic [15:0] a_fd_rxd;
  logic        a_fd_rxv;
  logic [7:0]  a_txq[$];
  int b_cyc, b_ss_falls, b_ss_fall_cyc, b_ss_rise_cyc, b_first_start, b_last_done;
  int b_fd_cnt, b_fd_cyc, b_stray, b_tx_bad;
  logic [31:0] b_fd_rxd;
  logic        b_fd_rxv;
  logic [7:0]  b_txq[$];

  spi_frame_tx_ctrl #(.DATA_W(14), .SS_SETUP_CYC(1), .SS_HOLD_CYC(1), .DROP_CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .i_trigger(a_trig), .i_data(a_data), .spi_start(a_start),
    .spi_tx_data(a_tx), .spi_rx_data(a_rx), .spi_done(a_done), .ss(a_ss), .o_busy(a_busy),
    .o_frame_done(a_fd), .o_rx_data(a_rxd), .o_rx_valid(a_rxv), .o_drop_cnt(a_drop));

  spi_frame_tx_ctrl #(.DATA_W(32), .SS_SETUP_CYC(3), .SS_HOLD_CYC(2), .DROP_CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .i_trigger(b_trig), .i_data(b_data), .spi_start(b_start),
    .spi_tx_data(b_tx), .spi_rx_data(b_rx), .spi_done(b_done), .ss(b_ss), .o_busy(b_busy),
    .o_frame_done(b_fd), .o_rx_data(b_rxd), .o_rx_valid(b_rxv), .o_drop_cnt(b_drop));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder and event log for instance A.
  initial begin : model_a
    int cd, k;
    logic ss_prev;
    logic [7:0] miso[4];
    miso = '{8'h5A, 8'hC3, 8'h11, 8'h00};
    cd = 0; k = 0; ss_prev = 1'b1;
    a_cyc = 0; a_ss_falls = 0; a_ss_fall_cyc = 0; a_ss_rise_cyc = 0; a_first_start = -1;
    a_last_done = 0; a_fd_cnt = 0; a_fd_cyc = 0; a_stray = 0; a_tx_bad = 0;
    a_fd_rxd = 16'h0000; a_fd_rxv = 1'b0; a_done = 1'b0; a_rx = 8'h00;
    forever begin
      @(negedge clk);
      a_cyc++;
      if (ss_prev && !a_ss) begin
        a_ss_falls++; a_ss_fall_cyc = a_cyc; a_txq.delete(); a_first_start = -1;
      end
      if (!ss_prev && a_ss) a_ss_rise_cyc = a_cyc;
      ss_prev = a_ss;
      if (a_fd) begin
        a_fd_cnt++; a_fd_cyc = a_cyc; a_fd_rxd = a_rxd; a_fd_rxv = a_rxv;
      end else if (a_rxv) begin
        a_stray++;
      end
      a_done = 1'b0;
      if (reset) begin
        cd = 0; k = 0;
      end else if (a_start) begin
        a_txq.push_back(a_tx);
        if (a_first_start < 0) a_first_start = a_cyc;
        cd = LAT;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (a_txq.size() > 0 && a_tx !== a_txq[$]) a_tx_bad++;
          a_done = 1'b1; a_rx = miso[k % 4]; k++; a_last_done = a_cyc;
        end
      end
      if (a_ss) k = 0;
    end
  end

  // Responder and event log for instance B.
  initial begin : model_b
    int cd, k;
    logic ss_prev;
    logic [7:0] miso[5];
    miso = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
    cd = 0; k = 0; ss_prev = 1'b1;
    b_cyc = 0; b_ss_falls = 0; b_ss_fall_cyc = 0; b_ss_rise_cyc = 0; b_first_start = -1;
    b_last_done = 0; b_fd_cnt = 0; b_fd_cyc = 0; b_stray = 0; b_tx_bad = 0;
    b_fd_rxd = 32'h0; b_fd_rxv = 1'b0; b_done = 1'b0; b_rx = 8'h00;
    forever begin
      @(negedge clk);
      b_cyc++;
      if (ss_prev && !b_ss) begin
        b_ss_falls++; b_ss_fall_cyc = b_cyc; b_txq.delete(); b_first_start = -1;
      end
      if (!ss_prev && b_ss) b_ss_rise_cyc = b_cyc;
      ss_prev = b_ss;
      if (b_fd) begin
        b_fd_cnt++; b_fd_cyc = b_cyc; b_fd_rxd = b_rxd; b_fd_rxv = b_rxv;
      end else if (b_rxv) begin
        b_stray++;
      end
      b_done = 1'b0;
      if (reset) begin
        cd = 0; k = 0;
      end else if (b_start) begin
        b_txq.push_back(b_tx);
        if (b_first_start < 0) b_first_start = b_cyc;
        cd = LAT;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (b_txq.size() > 0 && b_tx !== b_txq[$]) b_tx_bad++;
          b_done = 1'b1; b_rx = miso[k % 5]; k++; b_last_done = b_cyc;
        end
      end
      if (b_ss) k = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input bit sel_b, input int prev);
    int n;
    n = 0;
    while (((sel_b ? b_fd_cnt : a_fd_cnt) <= prev) && n < 800) begin
      @(negedge clk);
      n++;
    end
    check_eq(sel_b ? "b_frame_timeout" : "a_frame_timeout", (n < 800), 1);
    @(negedge clk);
  endtask

  task automatic check_tx(input bit sel_b, input logic [31:0] word, input int nb);
    logic [7:0] exp_q[$];
    logic [7:0] ck;
    int n;
    ck = 8'h00;
    for (int i = nb - 1; i >= 0; i--) begin
      exp_q.push_back(word[i*8 +: 8]);
      ck = ck ^ word[i*8 +: 8];
    end
`ifdef CHECKSUM_EN
    exp_q.push_back(ck);
`endif
    n = sel_b ? b_txq.size() : a_txq.size();
    check_eq(sel_b ? "b_tx_count" : "a_tx_count", n, exp_q.size());
    if (n == exp_q.size()) begin
      for (int i = 0; i < n; i++) begin
        check_eq(sel_b ? "b_tx_byte" : "a_tx_byte", sel_b ? b_txq[i] : a_txq[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_frame_a(input logic [13:0] word, input int falls, input int fds);
    check_tx(1'b0, 32'(word), 2);
    check_eq("a_setup_gap", a_first_start - a_ss_fall_cyc, 1);
    check_eq("a_done_to_frame_done", a_fd_cyc - a_last_done, 2);
    check_eq("a_done_to_ss_high", a_ss_rise_cyc - a_last_done, 2);
    check_eq("a_ss_windows", a_ss_falls, falls);
    check_eq("a_frame_done_count", a_fd_cnt, fds);
    check_eq("a_rx_data", a_fd_rxd, 16'h5AC3);
    check_eq("a_rx_valid_with_done", a_fd_rxv, 1'b1);
    check_eq("a_stray_or_unstable", a_stray + a_tx_bad, 0);
  endtask

  initial begin : stim
    checks = 0; errors = 0;
    reset = 1'b1;
    a_trig = 1'b0; a_data = 14'h0000; b_trig = 1'b0; b_data = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_a_ss", a_ss, 1'b1);
    check_eq("rst_a_busy", a_busy, 1'b0);
    check_eq("rst_a_start", a_start, 1'b0);
    check_eq("rst_a_tx", a_tx, 8'h00);
    check_eq("rst_a_frame_done", a_fd, 1'b0);
    check_eq("rst_a_rx_valid", a_rxv, 1'b0);
    check_eq("rst_a_rx_data", a_rxd, 16'h0000);
    check_eq("rst_a_drop", a_drop, 8'h00);
    check_eq("rst_b_ss", b_ss, 1'b1);
    check_eq("rst_b_drop", b_drop, 4'h0);
    reset = 1'b0;

    // Basic frame, i_data changed after the snapshot.
    @(negedge clk); a_trig = 1'b1; a_data = 14'h2ABC;
    @(negedge clk); a_trig = 1'b0; a_data = 14'h3FFF;
    check_eq("a_busy_after_trigger", a_busy, 1'b1);
    check_eq("a_ss_low_after_trigger", a_ss, 1'b0);
    wait_frame(1'b0, 0);
    check_frame_a(14'h2ABC, 1, 1);
    check_eq("a_idle_after_frame", a_busy, 1'b0);
    check_eq("a_drop_none", a_drop, 8'd0);

    // 20 triggers while busy.
    @(negedge clk); a_trig = 1'b1; a_data = 14'h2ABC;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); a_data = 14'(i * 397);
    end
    @(negedge clk); a_trig = 1'b0;
    wait_frame(1'b0, 1);
    check_frame_a(14'h2ABC, 2, 2);
    check_eq("a_drop_20", a_drop, 8'd20);

    // Trigger in the HOLD->IDLE exit cycle is dropped.
    repeat (3) @(negedge clk);
    a_trig = 1'b1; a_data = 14'h2ABC;
    @(negedge clk); a_trig = 1'b0;
    repeat (BUSY_A - 1) @(negedge clk);
    check_eq("a_hold_busy", a_busy, 1'b1);
    check_eq("a_hold_no_done_yet", a_fd, 1'b0);
    a_trig = 1'b1;
    @(negedge clk); a_trig = 1'b0;
    check_eq("a_exit_frame_done", a_fd, 1'b1);
    check_eq("a_exit_rx_valid", a_rxv, 1'b1);
    check_eq("a_exit_ss_high", a_ss, 1'b1);
    check_eq("a_exit_drop", a_drop, 8'd21);
    repeat (40) @(negedge clk);
    check_frame_a(14'h2ABC, 3, 3);
    check_eq("a_exit_no_new_frame", a_busy, 1'b0);

    // Reset during WAIT of the first byte.
    @(negedge clk); a_trig = 1'b1; a_data = 14'h2ABC;
    @(negedge clk); a_trig = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("a_pre_abort_busy", a_busy, 1'b1);
    check_eq("a_pre_abort_ss", a_ss, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("abort_ss", a_ss, 1'b1);
    check_eq("abort_busy", a_busy, 1'b0);
    check_eq("abort_start", a_start, 1'b0);
    check_eq("abort_tx", a_tx, 8'h00);
    check_eq("abort_frame_done", a_fd, 1'b0);
    check_eq("abort_rx_valid", a_rxv, 1'b0);
    check_eq("abort_rx_data", a_rxd, 16'h0000);
    check_eq("abort_drop", a_drop, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("abort_no_frame_done", a_fd_cnt, 3);
    @(negedge clk); a_trig = 1'b1; a_data = 14'h0155;
    @(negedge clk); a_trig = 1'b0;
    wait_frame(1'b0, 3);
    check_frame_a(14'h0155, 5, 4);

    // Wide configuration: long setup/hold, saturating 4-bit drop counter.
    @(negedge clk); b_trig = 1'b1; b_data = 32'hDEADBEEF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); b_data = 32'(i) * 32'h01010101;
    end
    @(negedge clk); b_trig = 1'b0;
    wait_frame(1'b1, 0);
    check_tx(1'b1, 32'hDEADBEEF, 4);
    check_eq("b_setup_gap", b_first_start - b_ss_fall_cyc, 3);
    check_eq("b_done_to_frame_done", b_fd_cyc - b_last_done, 3);
    check_eq("b_done_to_ss_high", b_ss_rise_cyc - b_last_done, 3);
    check_eq("b_ss_windows", b_ss_falls, 1);
    check_eq("b_rx_data", b_fd_rxd, 32'h01020304);
    check_eq("b_rx_valid_with_done", b_fd_rxv, 1'b1);
    check_eq("b_drop_saturated", b_drop, 4'hF);
    check_eq("b_stray_or_unstable", b_stray + b_tx_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
